// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, oversampled mid-bit sampling, 8N1 framing.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err reporting.
//   state     | meaning
//   IDLE      | line idle, waiting for falling edge
//   START     | qualifying start bit at mid-bit
//   DATA      | sampling 8 data bits, LSB first
//   PARITY    | sampling even-parity bit (UART_RX_PARITY_EN only)
//   STOP      | sampling stop bit, deliver byte or flag framing error
//   WAIT_IDLE | line held low after bad stop bit, wait for high
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t        state_q;
   logic          sync1_q;
   logic          rxs_q;
   logic [DW-1:0] divcnt_q;
   logic [SW-1:0] scnt_q;
   logic [2:0]    bidx_q;
   logic [7:0]    shift_q;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q;
   logic          frame_err_q;
   logic          tick;
   logic          start_det;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rx;
         rxs_q   <= sync1_q;
      end
   end

   assign tick      = (divcnt_q == DIV_LAST);
   assign start_det = (state_q == IDLE) && !rxs_q;

   // Divider restarts on the start edge so mid-bit lands a fixed distance after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divcnt_q <= '0;
      end else if (start_det || tick) begin
         divcnt_q <= '0;
      end else begin
         divcnt_q <= divcnt_q + 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad_q;
   logic parity_err_q;
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         scnt_q      <= '0;
         bidx_q      <= '0;
         shift_q     <= '0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  state_q <= START;
                  scnt_q  <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (scnt_q == SCNT_MID) begin
                     if (!rxs_q) begin
                        state_q <= DATA;
                        scnt_q  <= '0;
                        bidx_q  <= '0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (scnt_q == SCNT_LAST) begin
                     shift_q <= {rxs_q, shift_q[7:1]};
                     scnt_q  <= '0;
                     bidx_q  <= bidx_q + 3'd1;
                     if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                     end
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (scnt_q == SCNT_LAST) begin
                     par_bad_q <= rxs_q ^ (^shift_q);
                     scnt_q    <= '0;
                     state_q   <= STOP;
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (scnt_q == SCNT_LAST) begin
                     scnt_q <= '0;
                     if (rxs_q) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad_q;
`endif
                        state_q <= IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_IDLE;
                     end
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end
            WAIT_IDLE: begin
               if (rxs_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that turns the UART line into 8-bit bytes with a one-cycle valid strobe. It sits directly upstream of the command parser: its `rx_data`/`rx_valid` outputs drive the parser's inputs unchanged, and the parser then sets the PWM duty cycle. Framing is 8N1 with LSB first, mid-bit sampling from an oversampled tick, and frame-error detection.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bits/s.
- `OVERSAMPLE`, default 16: ticks per bit period; must be even and ≥ 4.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `rx`, input, 1: raw serial line, idle high; asynchronous to `clk`.
- `rx_data`, output, 8: last correctly framed byte.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` updates.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`, output, 1: one-cycle pulse on even-parity mismatch; tied 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- Tick generator:
  - Divider `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, integer truncation; `DIV` must be ≥ 1.
  - Counter counts 0..DIV-1 and emits `tick` on wrap.
  - Free-running, except it is cleared to 0 on the IDLE→START transition.
- Sample counter `scnt` (width clog2(OVERSAMPLE)) and bit index `bidx` (3 bits).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
  - IDLE: `rxs`==0 → START, with `scnt` cleared.
  - START: on the tick where `scnt`==OVERSAMPLE/2-1, check `rxs`. If 0 → DATA with `scnt`=0 and `bidx`=0. If 1 (glitch) → IDLE, no output.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift `rxs` into the shift register MSB-first, so the first received bit lands at bit 0. After `bidx`==7 → PARITY if enabled, else STOP.
  - PARITY: sample at mid-bit; compare against the XOR of the 8 data bits (even parity). Then → STOP.
  - STOP: sample at mid-bit.
    - `rxs`==1 → load `rx_data`, pulse `rx_valid` (and `parity_err` if there was a mismatch) → IDLE.
    - `rxs`==0 → pulse `frame_err`; `rx_data` is not updated and `rx_valid` stays low → WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`==1, then → IDLE. This absorbs breaks.
- A parity error does not suppress `rx_valid`. The byte is delivered with `parity_err` asserted in the same cycle.
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, state=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no strobe is produced. After release, the receiver waits in IDLE for the next falling edge, so a low line at release is taken as a start bit.

## Timing
- Input path latency: 2 `clk` cycles of synchronizer delay.
- `rx_valid` asserts on the `clk` edge after the mid-stop-bit tick, i.e. about 9.5 bit periods after the start-bit falling edge (10.5 with parity), plus 2–3 cycles. It is high for exactly one cycle.
- `rx_data` changes only in the same cycle that `rx_valid` goes high, and holds until the next valid byte.
- `rx_valid`, `frame_err` and `parity_err` are registered outputs. `rx_valid` and `frame_err` are never high together.
- Back-to-back frames are supported: return to IDLE at mid-stop leaves half a bit to catch the next start edge.
- No backpressure. The consumer must take `rx_data` on the `rx_valid` cycle or before the next strobe.
- Tolerates baud mismatch up to ±(OVERSAMPLE/2-1)/(OVERSAMPLE·10) of the bit period.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1 and the PARITY state is present.
  - `parity_err` pulses on an odd total count of ones over data plus parity.
- Not defined:
  - Frame is 8N1 and the PARITY state is absent.
  - `parity_err` is constant 0.

## Test plan
All scenarios use bench parameters CLK_FREQ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16, which gives DIV=1 and 16 `clk` per bit.

- Reset check: hold `rst_n`=0 with `rx`=1 → all outputs 0 and no strobes for 100 cycles after release.
- Send ASCII '5' (8'h35) 8N1 → exactly one `rx_valid` pulse, with `rx_data`=8'h35 and `frame_err`=0 in that cycle.
- Send 8'h30, 8'h39, 8'h41 back-to-back with no idle gap → three pulses carrying 8'h30, 8'h39, 8'h41, in order.
- Pull `rx` low for 4 clocks, then high → no strobe, and the FSM is back in IDLE. Then send 8'hA5 → `rx_data`=8'hA5.
- Send 8'h55 with the stop bit forced to 0, then hold `rx` low for 3 bit periods → one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged. The next frame, 8'h12, is received correctly.
- With `UART_RX_PARITY_EN`:
  - 8'h07 with parity bit 1 → `rx_valid`, `rx_data`=8'h07, `parity_err`=0.
  - 8'h07 with parity bit 0 → `rx_valid` and `parity_err` pulse together.
  - Assert `rst_n`=0 at bit 4 → no strobe, and the next frame decodes cleanly.
